// File: rtl/cymometer_pkg.sv
// Shared types and constants for the equal-precision frequency meter.
package cymometer_pkg;

    localparam int CNT_W = 32;
    localparam int DIV_W = 64;

    localparam logic [CNT_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE,
        ST_CLOSE,
        ST_DIV,
        ST_DONE
    } state_t;

    // Narrow a 64-bit quotient to the 32-bit result, saturating on overflow.
    function automatic logic [CNT_W-1:0] fold_quotient(
        input logic [DIV_W-1:0] q,
        input logic             zero_den
    );
        logic [CNT_W-1:0] res;
        if (zero_den) begin
            res = '0;
        end else if (|q[DIV_W-1:CNT_W]) begin
            res = SAT_VAL;
        end else begin
            res = q[CNT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/div_serial.sv
// Restoring shift-subtract divider, 64/32, one quotient bit per clock.
// done marks the cycle of the final iteration; quotient is final from the next cycle on.
module div_serial
    import cymometer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done,
    output logic             busy
);

    logic             r_busy;
    logic             r_zero;
    logic [5:0]       r_iter;
    logic [DIV_W-1:0] r_quo;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_den;

    logic [CNT_W:0]   w_shift;
    logic [CNT_W:0]   w_diff;
    logic             w_ge;
    logic [CNT_W:0]   w_rem_next;

    // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
    assign w_shift    = {r_rem, r_quo[DIV_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_den});
    assign w_diff     = w_shift - {1'b0, r_den};
    assign w_rem_next = w_ge ? w_diff : w_shift;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_zero <= 1'b0;
            r_iter <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
        end else if (!r_busy) begin
            if (start) begin
                r_busy <= 1'b1;
                r_zero <= (divisor == '0);
                r_iter <= '0;
                r_quo  <= dividend;
                r_rem  <= '0;
                r_den  <= divisor;
            end
        end else begin
            r_rem  <= w_rem_next[CNT_W-1:0];
            r_quo  <= {r_quo[DIV_W-2:0], w_ge};
            r_iter <= r_iter + 6'd1;
            if (r_iter == 6'd63) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign quotient = r_zero ? '0 : r_quo;
    assign done     = r_busy && (r_iter == 6'd63);
    assign busy     = r_busy;

endmodule

// File: rtl/cymo_meter.sv
// Equal-precision frequency meter: soft gate aligned to clk_fx edges,
// frequency = CLK_FS * fx_cnt / fs_cnt, one result per measurement.
module cymo_meter
    import cymometer_pkg::*;
#(
    parameter logic [CNT_W-1:0] CLK_FS         = 32'd50_000_000,
    parameter logic [CNT_W-1:0] GATE_CYCLES    = 32'd25_000_000,
    parameter logic [CNT_W-1:0] IDLE_CYCLES    = 32'd2_500_000,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_fx,
    output logic [CNT_W-1:0] data_fx,
    output logic             data_valid
);

    state_t           r_state;
    state_t           w_state_next;

    logic [2:0]       r_fx_pipe;
    logic             w_fx_rise;

    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] r_soft_cnt;
    logic [CNT_W-1:0] r_fs_cnt;
    logic [CNT_W-1:0] r_fx_cnt;
    logic             r_timeout;
    logic             r_div_first;
    logic [CNT_W-1:0] r_data_fx;
    logic             r_data_valid;

    logic             w_idle_hit;
    logic             w_tmo_hit;
    logic             w_gate_hit;
    logic             w_div_start;
    logic             w_div_done;
    logic             w_div_busy;
    logic [DIV_W-1:0] w_dividend;
    logic [DIV_W-1:0] w_quotient;
    logic [CNT_W-1:0] w_result;

    // Two synchronizer stages plus one edge-detect stage; the latency is the
    // same for the opening and closing edge, so it does not bias the counts.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_fx_pipe <= '0;
        end else begin
            r_fx_pipe <= {r_fx_pipe[1:0], clk_fx};
        end
    end

    assign w_fx_rise  = r_fx_pipe[1] & ~r_fx_pipe[2];

    assign w_idle_hit = (r_idle_cnt == IDLE_CYCLES - 32'd1);
    assign w_tmo_hit  = (r_tmo_cnt == TIMEOUT_CYCLES - 32'd1);
    assign w_gate_hit = (r_soft_cnt == GATE_CYCLES - 32'd1);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_idle_hit) w_state_next = ST_ARM;
            ST_ARM: begin
                if (w_fx_rise)      w_state_next = ST_GATE;
                else if (w_tmo_hit) w_state_next = ST_DONE;
            end
            ST_GATE:  if (w_gate_hit) w_state_next = ST_CLOSE;
            ST_CLOSE: begin
                if (w_fx_rise)      w_state_next = ST_DIV;
                else if (w_tmo_hit) w_state_next = ST_DONE;
            end
            ST_DIV:   if (w_div_done) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_soft_cnt   <= '0;
            r_fs_cnt     <= '0;
            r_fx_cnt     <= '0;
            r_timeout    <= 1'b0;
            r_div_first  <= 1'b0;
            r_data_fx    <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_div_first  <= (w_state_next == ST_DIV) && (r_state != ST_DIV);
            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= r_idle_cnt + 32'd1;
                    if (w_idle_hit) begin
                        r_idle_cnt <= '0;
                        r_tmo_cnt  <= '0;
                    end
                end
                ST_ARM: begin
                    r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    if (w_fx_rise) begin
                        r_fs_cnt   <= '0;
                        r_fx_cnt   <= '0;
                        r_soft_cnt <= '0;
                        r_timeout  <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                ST_GATE: begin
                    r_fs_cnt   <= r_fs_cnt + 32'd1;
                    r_soft_cnt <= r_soft_cnt + 32'd1;
                    if (w_fx_rise) begin
                        r_fx_cnt <= r_fx_cnt + 32'd1;
                    end
                    if (w_gate_hit) begin
                        r_tmo_cnt <= '0;
                    end
                end
                ST_CLOSE: begin
                    // The closing-edge cycle is counted too, so fs_cnt spans whole fx periods.
                    r_fs_cnt  <= r_fs_cnt + 32'd1;
                    r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    if (w_fx_rise) begin
                        r_fx_cnt <= r_fx_cnt + 32'd1;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_data_fx    <= r_timeout ? '0 : w_result;
                    r_data_valid <= 1'b1;
                    r_timeout    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_div_start = (r_state == ST_DIV) && r_div_first && !w_div_busy;
    assign w_dividend  = {{(DIV_W-CNT_W){1'b0}}, CLK_FS} * {{(DIV_W-CNT_W){1'b0}}, r_fx_cnt};
    assign w_result    = fold_quotient(w_quotient, (r_fs_cnt == '0));

    div_serial u_div (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (w_dividend),
        .divisor  (r_fs_cnt),
        .quotient (w_quotient),
        .done     (w_div_done),
        .busy     (w_div_busy)
    );

    assign data_fx    = r_data_fx;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_cymo_meter.sv
// Directed bench for cymo_meter: clk_fx is generated on clk_in negedges with a
// programmable period; each result is checked against hand-computed values.
module tb_cymo_meter;
    import cymometer_pkg::*;

    localparam logic [31:0] P_CLK_FS  = 32'd50_000_000;
    localparam logic [31:0] P_GATE    = 32'd2000;
    localparam logic [31:0] P_IDLE    = 32'd100;
    localparam logic [31:0] P_TIMEOUT = 32'd1000;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk_fx = 1'b0;
    logic [31:0] data_fx;
    logic        data_valid;

    int n_vec  = 0;
    int n_miss = 0;
    int n_txn  = 0;

    int fx_period = 100;
    bit fx_run    = 1'b0;
    int fx_phase  = 0;

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!fx_run) begin
            clk_fx   = 1'b0;
            fx_phase = 0;
        end else begin
            clk_fx = (fx_phase < fx_period / 2);
            if (fx_phase >= fx_period - 1) fx_phase = 0;
            else                           fx_phase = fx_phase + 1;
        end
    end

    cymo_meter #(
        .CLK_FS         (P_CLK_FS),
        .GATE_CYCLES    (P_GATE),
        .IDLE_CYCLES    (P_IDLE),
        .TIMEOUT_CYCLES (P_TIMEOUT)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clk_fx     (clk_fx),
        .data_fx    (data_fx),
        .data_valid (data_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int val, input int lo, input int hi);
        n_vec++;
        assert (val >= lo && val <= hi) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic wait_valid(input string tag, input int limit, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(posedge clk_in);
            #1;
            cycles++;
            if (data_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        assert (seen) else begin
            n_miss++;
            $error("FAIL %s: observed no data_valid expected one within %0d cycles", tag, limit);
        end
        if (seen) begin
            n_txn++;
            $display("txn %0d %s: data_fx=%0d after %0d cycles", n_txn, tag, data_fx, cycles);
        end
    endtask

    // data_valid must drop after one cycle while data_fx holds its value.
    task automatic check_pulse(input string tag, input logic [31:0] exp);
        @(posedge clk_in);
        #1;
        check_eq({tag, "_width"}, {31'd0, data_valid}, 32'd0);
        check_eq({tag, "_hold"}, data_fx, exp);
    endtask

    task automatic measure(input string tag, input logic [31:0] exp);
        int cyc;
        wait_valid(tag, 6000, cyc);
        check_eq(tag, data_fx, exp);
        check_pulse(tag, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int k;
        int pulses;

        // Reset state
        rst_n  = 1'b0;
        fx_run = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check_eq("rst_data", data_fx, 32'd0);
        check_eq("rst_valid", {31'd0, data_valid}, 32'd0);
        #1;
        rst_n = 1'b1;

        // clk_fx held low: ARM times out, 100 idle + 1000 wait + 1 done
        wait_valid("tmo_first", 3000, cyc);
        check_rng("tmo_first_lat", cyc, 1095, 1110);
        check_eq("tmo_first", data_fx, 32'd0);
        check_pulse("tmo_first", 32'd0);
        wait_valid("tmo_repeat", 3000, cyc);
        check_rng("tmo_repeat_lat", cyc, 1090, 1110);
        check_eq("tmo_repeat", data_fx, 32'd0);
        check_pulse("tmo_repeat", 32'd0);

        // Period 100: 50e6/100; the gate length is a multiple of the period,
        // so an edge lands exactly on soft-gate expiry.
        fx_period = 100;
        fx_run    = 1'b1;
        measure("p100_a", 32'd500_000);
        measure("p100_b", 32'd500_000);

        fx_period = 250;
        measure("p250", 32'd200_000);

        fx_period = 3;
        measure("p3", 32'd16_666_666);

        fx_period = 7;
        measure("p7", 32'd7_142_857);

        fx_period = 101;
        measure("p101", 32'd495_049);

        fx_period = 100;
        measure("p100_c", 32'd500_000);

        // Stop clk_fx inside the gate window: CLOSE times out with result 0
        repeat (1700) @(posedge clk_in);
        fx_run = 1'b0;
        measure("gate_stop", 32'd0);

        fx_run = 1'b1;
        measure("p100_d", 32'd500_000);

        // Reset while the divider is running
        k = 0;
        while (dut.r_state != ST_DIV && k < 4000) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        check_rng("div_reached", k, 0, 3999);
        repeat (20) @(posedge clk_in);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("div_rst_data", data_fx, 32'd0);
        check_eq("div_rst_valid", {31'd0, data_valid}, 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("div_rst_hold", data_fx, 32'd0);
        @(posedge clk_in);
        #2;
        rst_n = 1'b1;

        pulses = 0;
        repeat (2100) begin
            @(posedge clk_in);
            #1;
            if (data_valid === 1'b1) pulses++;
        end
        check_eq("post_rst_quiet", pulses, 32'd0);
        check_eq("post_rst_data", data_fx, 32'd0);
        measure("post_rst", 32'd500_000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
